// File: rtl/clk_divider_prog.sv
// Runtime-programmable clock divider with glitch-free divisor reload at period boundaries.
// Optional completed-period counter enabled by defining CLK_DIV_PERIOD_CNT_EN.
module clk_divider_prog #(
  parameter int WIDTH       = 16,
  parameter int DEFAULT_DIV = 8
`ifdef CLK_DIV_PERIOD_CNT_EN
  ,
  parameter int PCNT_W      = 16
`endif
) (
  input  logic             clk_in,
  input  logic             res_n,
  input  logic             en,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_valid,
  output logic             div_ready,
  output logic [WIDTH-1:0] div_cur,
  output logic             clk_out,
`ifdef CLK_DIV_PERIOD_CNT_EN
  output logic [PCNT_W-1:0] period_cnt,
`endif
  output logic             tick
);

  localparam logic [WIDTH-1:0] DEF = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] TWO = WIDTH'(2);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  logic             wrap;
  logic             load;
  logic             xfer;

  always_comb begin
    wrap       = en && (cnt_q == (div_q - ONE));
    // paused at the period start: apply even without en
    load       = pend_vld_q && (wrap || (!en && (cnt_q == '0)));
    xfer       = div_valid && !pend_vld_q;
    cnt_d      = cnt_q;
    div_d      = div_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    tick_d     = wrap;
    if (en) begin
      cnt_d = wrap ? '0 : (cnt_q + ONE);
    end
    if (load) begin
      div_d      = pend_q;
      pend_vld_d = 1'b0;
    end
    if (xfer) begin
      pend_d     = (div_in < TWO) ? TWO : div_in;
      pend_vld_d = 1'b1;
    end
    clk_d = (cnt_d >= (div_d - (div_d >> 1)));
  end

  always_ff @(posedge clk_in or negedge res_n) begin
    if (!res_n) begin
      cnt_q      <= '0;
      div_q      <= DEF;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      clk_q      <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      clk_q      <= clk_d;
      tick_q     <= tick_d;
    end
  end

`ifdef CLK_DIV_PERIOD_CNT_EN
  logic [PCNT_W-1:0] pcnt_q, pcnt_d;

  always_comb begin
    pcnt_d = pcnt_q;
    if (wrap) begin
      pcnt_d = pcnt_q + PCNT_W'(1);
    end
  end

  always_ff @(posedge clk_in or negedge res_n) begin
    if (!res_n) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

  assign period_cnt = pcnt_q;
`endif

  assign div_ready = !pend_vld_q;
  assign div_cur   = div_q;
  assign clk_out   = clk_q;
  assign tick      = tick_q;

endmodule
